// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry constants and FSM state encoding for the instruction cache.
//   ICACHE_INDEX_BITS : default number of index bits (2^N one-word lines)
//   ICACHE_TAG_BITS   : tag width for the default geometry (pc[17:N+2])
//   icache_state_t    : ICACHE_IDLE / ICACHE_MISS
package icache_pkg;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_TAG_BITS = 16 - ICACHE_INDEX_BITS;
    typedef enum logic {ICACHE_IDLE = 1'b0, ICACHE_MISS = 1'b1} icache_state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with combinational read and synchronous write.
//   clk_in, rst_in           : clock; async active-high reset clears the valid bits only
//   we, w_index, w_tag, w_data : line write port (sets valid)
//   r_index                  : line selected for reading
//   r_valid, r_tag, r_data   : contents of the selected line
import icache_pkg::*;

module icache_line_array #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS = 16 - INDEX_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] w_index,
    input  logic [TAG_BITS-1:0]   w_tag,
    input  logic [31:0]           w_data,
    input  logic [INDEX_BITS-1:0] r_index,
    output logic                  r_valid,
    output logic [TAG_BITS-1:0]   r_tag,
    output logic [31:0]           r_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES];

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) valid <= '0;
        else if (we) valid[w_index] <= 1'b1;

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk_in)
        if (we) begin
            tags[w_index] <= w_tag;
            data[w_index] <= w_data;
        end

    assign r_valid = valid[r_index];
    assign r_tag = tags[r_index];
    assign r_data = data[r_index];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
//   clk_in, rst_in, rdy_in : clock, async active-high reset, global stall (low freezes everything)
//   roll_back              : mispredict flush; cancels the pending fetch and any same-cycle request
//   fetch_start, pc        : fetch request from IF
//   finish_fetch, instruction_out, instruction_pc_out : registered one-cycle result
//   mc_fetch_start, mc_pc  : miss request held until mc_finish_fetch
//   mc_finish_fetch, mc_instruction_in : memory controller completion
import icache_pkg::*;

module icache #(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic        finish_fetch,
    output logic [31:0] instruction_out,
    output logic [31:0] instruction_pc_out,
    output logic        mc_fetch_start,
    output logic [31:0] mc_pc,
    input  logic        mc_finish_fetch,
    input  logic [31:0] mc_instruction_in
);
    localparam int TAG_BITS = 16 - INDEX_BITS;

    icache_state_t       state, state_next;
    logic [31:0]         req_pc;
    logic                r_valid;
    logic [TAG_BITS-1:0] r_tag;
    logic [31:0]         r_data;
    logic                start, hit, fill;

    icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) lines (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .we       (rdy_in && fill),
        .w_index  (req_pc[INDEX_BITS+1:2]),
        .w_tag    (req_pc[17:INDEX_BITS+2]),
        .w_data   (mc_instruction_in),
        .r_index  (pc[INDEX_BITS+1:2]),
        .r_valid  (r_valid),
        .r_tag    (r_tag),
        .r_data   (r_data)
    );

    // Fill happens even under roll_back: the returned word is correct for req_pc.
    always_comb begin
        start = state == ICACHE_IDLE && fetch_start && !roll_back;
        hit = r_valid && r_tag == pc[17:INDEX_BITS+2];
        fill = state == ICACHE_MISS && mc_finish_fetch;
        state_next = roll_back || fill ? ICACHE_IDLE : start && !hit ? ICACHE_MISS : state;
    end

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= ICACHE_IDLE;
        else if (rdy_in) state <= state_next;

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            finish_fetch <= 1'b0;
            instruction_out <= '0;
            instruction_pc_out <= '0;
            mc_fetch_start <= 1'b0;
            mc_pc <= '0;
            req_pc <= '0;
        end else if (rdy_in) begin
            finish_fetch <= !roll_back && (fill || (start && hit));
            mc_fetch_start <= state_next == ICACHE_MISS;
            if (start) req_pc <= pc;
            if (start && !hit) mc_pc <= pc;
            if (start && hit) begin
                instruction_out <= r_data;
                instruction_pc_out <= pc;
            end
            if (fill && !roll_back) begin
                instruction_out <= mc_instruction_in;
                instruction_pc_out <= req_pc;
            end
        end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized fetch sequences checked against a line-level cache model.
module tb_icache;
    logic        clk_in = 0;
    logic        rst_in = 1;
    logic        rdy_in = 1;
    logic        roll_back = 0;
    logic        fetch_start = 0;
    logic [31:0] pc = 0;
    logic        finish_fetch;
    logic [31:0] instruction_out;
    logic [31:0] instruction_pc_out;
    logic        mc_fetch_start;
    logic [31:0] mc_pc;
    logic        mc_finish_fetch = 0;
    logic [31:0] mc_instruction_in = 0;

    int compared = 0;
    int mismatched = 0;

    // Model: for each line index, which word address (pc[17:2]) it holds and its data.
    logic [15:0] cached [int];
    logic [31:0] cdata [int];
    logic [31:0] last_instr = 0;
    logic [31:0] last_pc = 0;

    icache dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .roll_back         (roll_back),
        .fetch_start       (fetch_start),
        .pc                (pc),
        .finish_fetch      (finish_fetch),
        .instruction_out   (instruction_out),
        .instruction_pc_out(instruction_pc_out),
        .mc_fetch_start    (mc_fetch_start),
        .mc_pc             (mc_pc),
        .mc_finish_fetch   (mc_finish_fetch),
        .mc_instruction_in (mc_instruction_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", nm, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        if (!cached.exists(idx_of(a))) return 0;
        return cached[idx_of(a)] == a[17:2];
    endfunction

    // Completes an outstanding miss for address a with data d.
    task automatic miss_done(input string nm, input logic [31:0] a, input logic [31:0] d);
        mc_finish_fetch = 1;
        mc_instruction_in = d;
        step();
        mc_finish_fetch = 0;
        mc_instruction_in = $urandom;
        cached[idx_of(a)] = a[17:2];
        cdata[idx_of(a)] = d;
        last_instr = d;
        last_pc = a;
        check({nm, ".fill_finish"}, 32'(finish_fetch), 1);
        check({nm, ".fill_instr"}, instruction_out, d);
        check({nm, ".fill_pc"}, instruction_pc_out, a);
        check({nm, ".fill_mc_drop"}, 32'(mc_fetch_start), 0);
        step();
        check({nm, ".one_pulse"}, 32'(finish_fetch), 0);
    endtask

    // Issues a fetch; on a miss the memory answers after lat stall cycles with d.
    task automatic fetch(input string nm, input logic [31:0] a, input int lat, input logic [31:0] d);
        bit h;
        h = model_hit(a);
        fetch_start = 1;
        pc = a;
        step();
        fetch_start = 0;
        pc = $urandom;
        if (h) begin
            last_instr = cdata[idx_of(a)];
            last_pc = a;
            check({nm, ".hit_finish"}, 32'(finish_fetch), 1);
            check({nm, ".hit_instr"}, instruction_out, last_instr);
            check({nm, ".hit_pc"}, instruction_pc_out, a);
            check({nm, ".hit_no_mc"}, 32'(mc_fetch_start), 0);
            step();
            check({nm, ".one_pulse"}, 32'(finish_fetch), 0);
        end else begin
            check({nm, ".mc_start"}, 32'(mc_fetch_start), 1);
            check({nm, ".mc_pc"}, mc_pc, a);
            check({nm, ".no_early_finish"}, 32'(finish_fetch), 0);
            for (int i = 0; i < lat; i++) begin
                step();
                check({nm, ".mc_hold"}, 32'(mc_fetch_start), 1);
                check({nm, ".wait_quiet"}, 32'(finish_fetch), 0);
            end
            miss_done(nm, a, d);
        end
    endtask

    initial begin
        logic [31:0] a;
        repeat (2) step();
        check("reset.finish", 32'(finish_fetch), 0);
        check("reset.mc_start", 32'(mc_fetch_start), 0);
        check("reset.instr", instruction_out, 0);
        check("reset.instr_pc", instruction_pc_out, 0);
        check("reset.mc_pc", mc_pc, 0);
        rst_in = 0;
        step();

        fetch("cold", 32'h0000_0004, 2, 32'h0000_0013);
        fetch("hit", 32'h0000_0004, 0, 32'h0);
        fetch("conflict", 32'h0000_0104, 1, 32'hDEAD_BEEF);
        fetch("remiss", 32'h0000_0004, 0, 32'h0000_0013);
        fetch("high_bits_ignored", 32'hFFFC_0004, 0, 32'h0);

        // roll_back while a miss is pending
        a = 32'h0000_0200;
        fetch_start = 1;
        pc = a;
        step();
        fetch_start = 0;
        check("rb.mc_start", 32'(mc_fetch_start), 1);
        step();
        roll_back = 1;
        step();
        roll_back = 0;
        check("rb.mc_drop", 32'(mc_fetch_start), 0);
        check("rb.no_finish", 32'(finish_fetch), 0);
        mc_finish_fetch = 1;
        mc_instruction_in = 32'h5555_AAAA;
        step();
        mc_finish_fetch = 0;
        check("rb.late_mc_ignored", 32'(finish_fetch), 0);
        check("rb.idle_mc", 32'(mc_fetch_start), 0);
        fetch("rb.refetch_misses", a, 1, 32'h0000_0A0A);

        // roll_back coinciding with mc_finish_fetch: no pulse, but the line fills
        a = 32'h0000_0308;
        fetch_start = 1;
        pc = a;
        step();
        fetch_start = 0;
        check("rbf.mc_start", 32'(mc_fetch_start), 1);
        roll_back = 1;
        mc_finish_fetch = 1;
        mc_instruction_in = 32'hCAFE_F00D;
        step();
        roll_back = 0;
        mc_finish_fetch = 0;
        cached[idx_of(a)] = a[17:2];
        cdata[idx_of(a)] = 32'hCAFE_F00D;
        check("rbf.no_finish", 32'(finish_fetch), 0);
        check("rbf.mc_drop", 32'(mc_fetch_start), 0);
        step();
        check("rbf.still_quiet", 32'(finish_fetch), 0);
        fetch("rbf.hit_after", a, 0, 32'h0);

        // roll_back discards a same-cycle fetch_start
        fetch_start = 1;
        roll_back = 1;
        pc = 32'h0000_0710;
        step();
        fetch_start = 0;
        roll_back = 0;
        check("rbs.no_mc", 32'(mc_fetch_start), 0);
        check("rbs.no_finish", 32'(finish_fetch), 0);

        // freeze during MISS, with an mc pulse that must be ignored
        a = 32'h0000_0310;
        fetch_start = 1;
        pc = a;
        step();
        fetch_start = 0;
        check("frz.mc_start", 32'(mc_fetch_start), 1);
        rdy_in = 0;
        for (int i = 0; i < 5; i++) begin
            mc_finish_fetch = (i == 2);
            mc_instruction_in = 32'hBAD0_0000;
            roll_back = (i == 4);
            step();
            check("frz.mc_held", 32'(mc_fetch_start), 1);
            check("frz.mc_pc", mc_pc, a);
            check("frz.no_finish", 32'(finish_fetch), 0);
            check("frz.instr_held", instruction_out, last_instr);
            check("frz.pc_held", instruction_pc_out, last_pc);
        end
        mc_finish_fetch = 0;
        roll_back = 0;
        rdy_in = 1;
        miss_done("frz.resume", a, 32'h1234_5678);
        fetch("frz.hit_after", a, 0, 32'h0);

        // asynchronous reset in the middle of a miss
        fetch("rst.prime", 32'h0000_0004, 0, 32'h0);
        a = 32'h0000_0114;
        fetch_start = 1;
        pc = a;
        step();
        fetch_start = 0;
        check("rst.mc_start", 32'(mc_fetch_start), 1);
        #2;
        rst_in = 1;
        #1;
        check("rst.async_mc", 32'(mc_fetch_start), 0);
        check("rst.async_mc_pc", mc_pc, 0);
        check("rst.async_instr", instruction_out, 0);
        check("rst.async_pc", instruction_pc_out, 0);
        check("rst.async_finish", 32'(finish_fetch), 0);
        step();
        rst_in = 0;
        cached.delete();
        cdata.delete();
        last_instr = 0;
        last_pc = 0;
        mc_finish_fetch = 1;
        step();
        mc_finish_fetch = 0;
        check("rst.stale_mc_ignored", 32'(finish_fetch), 0);
        check("rst.stale_mc_idle", 32'(mc_fetch_start), 0);
        fetch("rst.was_hit_now_miss", 32'h0000_0004, 1, 32'h0000_0093);

        // random fetches over a few indices and tags so hits, misses and conflicts mix
        for (int n = 0; n < 40; n++) begin
            a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            fetch("rand", a, $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
